// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle via a trial subtraction.
// Optional feature: define DIV_EARLY_EXIT_EN to skip the iterations when |B| > |A|.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivZero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam int CW = $clog2(N);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  r_q, r_d, q_q, q_d, b_q, b_d;
    logic          sa_q, sa_d, sq_q, sq_d;
    logic [N-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic          divz_q, divz_d;

    logic [N-1:0]  abs_a, abs_b, r_sh, r_iter, q_iter;
    logic [N:0]    trial_sum;
    logic          take, accept;

    assign abs_a = (signed_op & A[N-1]) ? -A : A;
    assign abs_b = (signed_op & B[N-1]) ? -B : B;

    // Trial subtraction R_sh + ~B + 1; carry out set means no borrow.
    assign r_sh      = {r_q[N-2:0], q_q[N-1]};
    assign trial_sum = {1'b0, r_sh} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
    // A set bit shifted out of R makes the true partial remainder exceed any divisor.
    assign take      = trial_sum[N] | r_q[N-1];
    assign r_iter    = take ? trial_sum[N-1:0] : r_sh;
    assign q_iter    = {q_q[N-2:0], take};

    assign accept = start & ((state_q == IDLE) | (state_q == FIN));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sq_d    = sq_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        divz_d  = divz_q;
        case (state_q)
            IDLE, FIN: begin
                if (accept) begin
                    r_d     = '0;
                    q_d     = abs_a;
                    b_d     = abs_b;
                    sa_d    = A[N-1] & signed_op;
                    sq_d    = (A[N-1] ^ B[N-1]) & signed_op;
                    count_d = CW'(N - 1);
                    if (B == '0) begin
                        state_d = FIN;
                        quot_d  = '1;
                        rem_d   = A;
                        divz_d  = 1'b1;
                    end else begin
                        divz_d  = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
                        if (abs_b > abs_a) begin
                            state_d = FIN;
                            quot_d  = '0;
                            rem_d   = A;
                        end else begin
                            state_d = RUN;
                        end
`else
                        state_d = RUN;
`endif
                    end
                end else if (state_q == FIN) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d = r_iter;
                q_d = q_iter;
                if (count_q == '0) begin
                    state_d = FIN;
                    quot_d  = sq_q ? -q_iter : q_iter;
                    rem_d   = sa_q ? -r_iter : r_iter;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sq_q    <= sq_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            divz_q  <= divz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = divz_q;
endmodule
